// File: rtl/paddle_mapper.sv
// ============================================================================
// paddle_mapper: 4-sample moving average, screen scaling and deadband for two paddle pots
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module paddle_mapper #(
  parameter int SCREEN_H = 480,
  parameter int PADDLE_H = 80,
  parameter int DEADBAND = 2
) (
  input  logic       clock_50MHz,
  input  logic       rst,
  input  logic       busy,
  input  logic [7:0] data_ad0,
  input  logic [7:0] data_ad1,
  output logic [9:0] p1y,
  output logic [9:0] p2y,
  output logic       upd,
  output logic       overrun
);

  localparam int         Y_SPAN  = SCREEN_H - PADDLE_H;
  localparam logic [9:0] Y_MID   = 10'(Y_SPAN / 2);
  localparam logic [8:0] SPAN9   = 9'(Y_SPAN);
  localparam logic [9:0] DB10    = 10'(DEADBAND);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_SCALE, S_UPD} state_t;

  state_t     state;
  logic       busy_q;
  logic       armed;
  logic       primed;
  logic       loaded;
  logic [7:0] cap    [2];
  logic [7:0] hist   [2][4];
  logic [9:0] sum    [2];
  logic [9:0] scaled [2];
  logic [9:0] py     [2];

  logic [16:0] prod       [2];
  logic [9:0]  scaled_nxt [2];
  logic [9:0]  diff       [2];
  logic        move       [2];
  logic        sample_evt;

  // busy_q resets high; the first cycle after reset is masked so a busy line
  // already low at reset release does not look like a fresh conversion.
  assign sample_evt = armed && busy_q && !busy;

  always_comb begin
    for (int ch = 0; ch < 2; ch++) begin
      prod[ch]       = 17'(sum[ch][9:2]) * 17'(SPAN9);
      scaled_nxt[ch] = 10'(prod[ch] >> 8);
      diff[ch]       = (scaled[ch] >= py[ch]) ? (scaled[ch] - py[ch]) : (py[ch] - scaled[ch]);
      move[ch]       = !loaded || (diff[ch] > DB10);
    end
  end

  always_ff @(posedge clock_50MHz) begin
    if (rst) begin
      state   <= S_IDLE;
      busy_q  <= 1'b1;
      armed   <= 1'b0;
      primed  <= 1'b0;
      loaded  <= 1'b0;
      upd     <= 1'b0;
      overrun <= 1'b0;
      for (int ch = 0; ch < 2; ch++) begin
        cap[ch]    <= '0;
        sum[ch]    <= '0;
        scaled[ch] <= '0;
        py[ch]     <= Y_MID;
        for (int k = 0; k < 4; k++) hist[ch][k] <= '0;
      end
    end else begin
      busy_q <= busy;
      armed  <= 1'b1;
      upd    <= 1'b0;
      if (sample_evt && state != S_IDLE) overrun <= 1'b1;

      case (state)
        S_IDLE: begin
          if (sample_evt) begin
            cap[0] <= data_ad0;
            cap[1] <= data_ad1;
            state  <= S_ACC;
          end
        end
        S_ACC: begin
          for (int ch = 0; ch < 2; ch++) begin
            if (!primed) begin
              for (int k = 0; k < 4; k++) hist[ch][k] <= cap[ch];
              sum[ch] <= {cap[ch], 2'b00};
            end else begin
              hist[ch][0] <= cap[ch];
              for (int k = 1; k < 4; k++) hist[ch][k] <= hist[ch][k-1];
              // Modulo-1024 arithmetic is exact here: the oldest entry is part of sum.
              sum[ch] <= sum[ch] + {2'b00, cap[ch]} - {2'b00, hist[ch][3]};
            end
          end
          primed <= 1'b1;
          state  <= S_SCALE;
        end
        S_SCALE: begin
          scaled[0] <= scaled_nxt[0];
          scaled[1] <= scaled_nxt[1];
          state     <= S_UPD;
        end
        S_UPD: begin
          for (int ch = 0; ch < 2; ch++) begin
            if (move[ch]) py[ch] <= scaled[ch];
          end
          loaded <= 1'b1;
          upd    <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign p1y = py[0];
  assign p2y = py[1];

endmodule

`default_nettype wire
